spi_master: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0), MSB-first bus master that runs full-duplex frames against the FPGA-side `spi_slave` or any external mode-0 slave. It latches a parallel word on `start`, generates `ss`/`sck`/`mosi`, shifts `miso` into a receive register, and pulses `done` when the frame completes. It sits between application logic (start/data handshake) and the JA/XADC pin mapping in board top levels.

---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_half_tick.sv | 39 +++
 rtl/spi_master.sv | 194 +++++++++++++++++++
 tb/tb_spi_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding, default
// frame width and divider, the minimum legal divider, and the sck idle level.
package spi_master_pkg;

  localparam int unsigned SPI_DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned SPI_DEFAULT_CLK_DIV    = 4;

  // Two cycles are spent in the miso synchronizer. Anything shorter than
  // four leaves the slave no time to settle miso before the rising edge.
  localparam int unsigned SPI_MIN_CLK_DIV = 4;

  // Mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on the rising edge).
  localparam logic SPI_SCK_IDLE = 1'b0;

  typedef enum logic [2:0] {
    SPI_ST_IDLE  = 3'd0,
    SPI_ST_LEAD  = 3'd1,
    SPI_ST_HIGH  = 3'd2,
    SPI_ST_LOW   = 3'd3,
    SPI_ST_TRAIL = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer for the SPI master.
// A CLK_DIV-cycle down-counter. Assert restart in the cycle a state is
// entered; tick is then high for one cycle, CLK_DIV cycles later.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   restart  synchronous reload to CLK_DIV-1
//   tick     high while the count has expired
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Not gated by restart: the FSM derives restart from tick, so gating
  // would close a combinational loop.
  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first, full-duplex bus master.
// Latches send_data on an accepted start and drives ss/sck/mosi. It shifts
// the synchronized miso into a receive register and pulses done at frame end.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      frame request, only looked at while idle
//   send_data  word to transmit, latched on the accepting edge
//   recv_data  last received word, updated in the done cycle
//   busy       high from the accepting edge up to (not including) done
//   done       one-cycle pulse at frame end
//   ss         active-low slave select
//   sck        serial clock, idles low
//   mosi       serial data out
//   miso       serial data in, asynchronous to clk
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic [DATA_WIDTH-1:0] recv_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ss,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("spi_master: DATA_WIDTH must be at least 1");
  end

  spi_state_e            state_q, state_d;
  logic                  ss_q, ss_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] recv_q, recv_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;   // bits still to be clocked
  logic                  trail_half_q, trail_half_d;
  logic                  miso_s1_q, miso_s2_q;
  logic                  restart;
  logic                  tick;
  logic [DATA_WIDTH-1:0] tx_shift;

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign tx_shift = tx_q << 1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    ss_d         = ss_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tx_d         = tx_q;
    rx_d         = rx_q;
    recv_d       = recv_q;
    bit_cnt_d    = bit_cnt_q;
    trail_half_d = trail_half_q;
    restart      = 1'b0;

    case (state_q)
      SPI_ST_IDLE: begin
        // Keep the timer loaded so LEAD starts a full half-period.
        restart = 1'b1;
        if (start) begin
          state_d   = SPI_ST_LEAD;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          tx_d      = send_data;
          mosi_d    = send_data[DATA_WIDTH-1];
          rx_d      = '0;
          bit_cnt_d = BW'(DATA_WIDTH);
        end
      end

      SPI_ST_LEAD, SPI_ST_LOW: begin
        if (tick) begin
          state_d = SPI_ST_HIGH;
          sck_d   = ~SPI_SCK_IDLE;
          rx_d    = (rx_q << 1) | DATA_WIDTH'(miso_s2_q);
          restart = 1'b1;
        end
      end

      SPI_ST_HIGH: begin
        if (tick) begin
          sck_d     = SPI_SCK_IDLE;
          bit_cnt_d = bit_cnt_q - BW'(1);
          restart   = 1'b1;
          if (bit_cnt_q > BW'(1)) begin
            state_d = SPI_ST_LOW;
            tx_d    = tx_shift;
            mosi_d  = tx_shift[DATA_WIDTH-1];
          end else begin
            state_d      = SPI_ST_TRAIL;
            trail_half_d = 1'b0;
          end
        end
      end

      SPI_ST_TRAIL: begin
        // Spans two half-periods: the low phase after the last bit, then
        // the ss hold time, so ss rises one full sck period after the
        // final falling edge.
        if (tick) begin
          restart = 1'b1;
          if (!trail_half_q) begin
            trail_half_d = 1'b1;
          end else begin
            state_d      = SPI_ST_IDLE;
            trail_half_d = 1'b0;
            ss_d         = 1'b1;
            mosi_d       = 1'b0;
            busy_d       = 1'b0;
            recv_d       = rx_q;
            done_d       = 1'b1;
          end
        end
      end

      default: begin
        state_d = SPI_ST_IDLE;
      end
    endcase
  end

  // NOTE: every flop, datapath included, is reset, so a frame aborted by
  // reset leaves no stale bits behind for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SPI_ST_IDLE;
      ss_q         <= 1'b1;
      sck_q        <= SPI_SCK_IDLE;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      recv_q       <= '0;
      bit_cnt_q    <= '0;
      trail_half_q <= 1'b0;
      miso_s1_q    <= 1'b0;
      miso_s2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_q         <= ss_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      recv_q       <= recv_d;
      bit_cnt_q    <= bit_cnt_d;
      trail_half_q <= trail_half_d;
      miso_s1_q    <= miso;
      miso_s2_q    <= miso_s1_q;
    end
  end

  assign recv_data = recv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ss        = ss_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: one default instance (8 bits, divider 4)
// and one 12-bit / divider-6 instance, both in loopback except when the
// behavioural mode-0 slave drives miso of the default instance.
module tb_spi_master;

  typedef struct packed {
    logic [7:0] recv;
    logic [7:0] mosi;
    int         done_cyc;
  } exp_t;

  typedef struct packed {
    logic [11:0] recv;
    int          done_cyc;
  } exp12_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  send_data;
  logic [7:0]  recv_data;
  logic        busy, done, ss, sck, mosi, miso;
  logic        loop;

  logic        start2;
  logic [11:0] send2;
  logic [11:0] recv2;
  logic        busy2, done2, ss2, sck2, mosi2;

  int          cyc;
  int          checks;
  int          errors;

  exp_t        sb_q[$];
  exp12_t      sb2_q[$];
  exp_t        mon_e;
  exp12_t      mon2_e;

  spi_master u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .send_data (send_data),
    .recv_data (recv_data),
    .busy      (busy),
    .done      (done),
    .ss        (ss),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso)
  );

  spi_master #(
    .DATA_WIDTH (12),
    .CLK_DIV    (6)
  ) u_dut12 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .send_data (send2),
    .recv_data (recv2),
    .busy      (busy2),
    .done      (done2),
    .ss        (ss2),
    .sck       (sck2),
    .mosi      (mosi2),
    .miso      (mosi2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural mode-0 slave ----------------
  logic [7:0] slv_word;
  logic [7:0] slv_tx;
  logic [7:0] slv_rx;
  logic       slv_ss_q  = 1'b1;
  logic       slv_sck_q = 1'b0;

  initial begin
    slv_word = 8'h3C;
    slv_tx   = 8'h00;
    slv_rx   = 8'h00;
  end

  always @(ss or sck) begin
    if (!ss && slv_ss_q) begin
      slv_tx = slv_word;
      slv_rx = 8'h00;
    end else if (!ss && sck && !slv_sck_q) begin
      slv_rx = {slv_rx[6:0], mosi};
    end else if (!ss && !sck && slv_sck_q) begin
      slv_tx = {slv_tx[6:0], 1'b0};
    end
    slv_ss_q  = ss;
    slv_sck_q = sck;
  end

  assign miso = loop ? mosi : slv_tx[7];

  // ---------------- monitor for the default instance ----------------
  int         ss_low_cnt;
  int         ss_high_cnt;
  int         last_gap;
  int         rise_cnt;
  logic [7:0] mosi_word;
  logic       prev_sck;
  logic       prev_ss;

  initial begin
    ss_low_cnt  = 0;
    ss_high_cnt = 0;
    last_gap    = -1;
    rise_cnt    = 0;
    mosi_word   = 8'h00;
    prev_sck    = 1'b0;
    prev_ss     = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      ss_low_cnt  = 0;
      ss_high_cnt = 0;
      rise_cnt    = 0;
      mosi_word   = 8'h00;
      prev_sck    = 1'b0;
      prev_ss     = 1'b1;
    end else begin
      if (!ss && prev_ss) begin
        last_gap   = ss_high_cnt;
        ss_low_cnt = 0;
        rise_cnt   = 0;
        mosi_word  = 8'h00;
      end
      if (ss && !prev_ss) ss_high_cnt = 0;
      if (sck && !prev_sck) begin
        rise_cnt++;
        mosi_word = {mosi_word[6:0], mosi};
      end
      if (ss) ss_high_cnt++;
      else    ss_low_cnt++;

      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_expected", 32'd0, 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("recv_data",     {24'd0, recv_data}, {24'd0, mon_e.recv});
          check("mosi_bits",     {24'd0, mosi_word}, {24'd0, mon_e.mosi});
          check("done_cycle",    cyc,         mon_e.done_cyc);
          check("sck_rises",     rise_cnt,    32'd8);
          check("ss_low_cycles", ss_low_cnt,  32'd72);
          check("busy_in_done",  {31'd0, busy}, 32'd0);
        end
      end
      prev_sck = sck;
      prev_ss  = ss;
    end
  end

  // ---------------- monitor for the 12-bit instance ----------------
  always @(negedge clk) begin
    if (rst && done2) begin
      if (sb2_q.size() == 0) begin
        check("done12_expected", 32'd0, 32'd1);
      end else begin
        mon2_e = sb2_q.pop_front();
        check("recv12_data",  {20'd0, recv2}, {20'd0, mon2_e.recv});
        check("done12_cycle", cyc,            mon2_e.done_cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Pulse start for one cycle; t0 is the accepting edge.
  task automatic issue(input logic [7:0] data, input bit expect_done,
                       input logic [7:0] exp_recv, output int t0);
    exp_t e;
    t0 = cyc + 1;
    if (expect_done) begin
      e.recv     = exp_recv;
      e.mosi     = data;
      e.done_cyc = t0 + 72;
      sb_q.push_back(e);
    end
    send_data = data;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int     t0;
    exp_t   e;
    exp12_t e2;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    send_data = 8'h00;
    loop      = 1'b1;
    start2    = 1'b0;
    send2     = 12'h000;

    repeat (3) @(negedge clk);
    check("rst_ss",    {31'd0, ss},   32'd1);
    check("rst_sck",   {31'd0, sck},  32'd0);
    check("rst_mosi",  {31'd0, mosi}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_recv",  {24'd0, recv_data}, 32'd0);
    check("rst_ss12",  {31'd0, ss2},  32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, 8'hA5.
    issue(8'hA5, 1'b1, 8'hA5, t0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ss_after_accept",   {31'd0, ss},   32'd0);
    wait_cyc(t0 + 80);

    // Behavioural slave returns 8'h3C while the master sends 8'hF0.
    loop = 1'b0;
    issue(8'hF0, 1'b1, 8'h3C, t0);
    wait_cyc(t0 + 80);
    check("slave_captured", {24'd0, slv_rx}, 32'h0000_00F0);
    loop = 1'b1;

    // start re-pulsed mid-frame and send_data changed mid-frame.
    issue(8'h96, 1'b1, 8'h96, t0);
    wait_cyc(t0 + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 19);
    send_data = 8'h00;
    wait_cyc(t0 + 39);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 85);

    // start held high across three frames of 8'h81.
    t0 = cyc + 1;
    e.recv = 8'h81;
    e.mosi = 8'h81;
    e.done_cyc = t0 + 72;  sb_q.push_back(e);
    e.done_cyc = t0 + 145; sb_q.push_back(e);
    e.done_cyc = t0 + 218; sb_q.push_back(e);
    send_data = 8'h81;
    start     = 1'b1;
    wait_cyc(t0 + 80);
    check("ss_gap_1_2", last_gap, 32'd1);
    wait_cyc(t0 + 150);
    check("ss_gap_2_3", last_gap, 32'd1);
    start = 1'b0;
    wait_cyc(t0 + 230);

    // Reset in the middle of a frame: no done, outputs back to reset values.
    issue(8'hC3, 1'b0, 8'h00, t0);
    wait_cyc(t0 + 30);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_ss",   {31'd0, ss},   32'd1);
    check("abort_sck",  {31'd0, sck},  32'd0);
    check("abort_mosi", {31'd0, mosi}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_recv", {24'd0, recv_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    issue(8'h3A, 1'b1, 8'h3A, t0);
    wait_cyc(t0 + 80);

    // 12-bit, divider-6 instance in loopback.
    t0 = cyc + 1;
    e2.recv     = 12'hF55;
    e2.done_cyc = t0 + 156;
    sb2_q.push_back(e2);
    send2  = 12'hF55;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_cyc(t0 + 165);

    check("frames_outstanding",   sb_q.size(),  32'd0);
    check("frames12_outstanding", sb2_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
